conv_window_addr_gen: RTL and testbench
=======================================

CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

Interface
REQ-001 Parameter VECTOR_SIZE, default 8: number of lanes issued per beat; power of two, at least 1.
REQ-002 Parameter ADDR_WIDTH, default 12: element-address width per lane.
REQ-003 Parameter DIM_WIDTH, default 8: width of every dimension and stride input.
REQ-004 Clock and reset: one clock, clkIn; reset rstIn is synchronous and active-low.
REQ-005 Inputs, DIM_WIDTH each: dataRowsIn, dataColsIn, filtRowsIn, filtColsIn, strideIn (image dims, filter dims, stride).
REQ-006 Inputs, ADDR_WIDTH each: dataBaseIn, filtBaseIn (base element addresses).
REQ-007 Handshake inputs, 1 bit each: startIn (request a run), readyIn (downstream accepts the current beat).
REQ-008 Address outputs, VECTOR_SIZE*ADDR_WIDTH each: dataAddrOut and filtAddrOut; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Output laneValidOut, VECTOR_SIZE bits: per-lane valid mask for the current beat.
REQ-010 Outputs, 1 bit each:
- validOut: beat present.
- lastOut: final beat of a window.
- busyOut: run in progress.
- doneOut: run-complete pulse.
- errOut: illegal-configuration pulse.

Function
REQ-011 The block shall use states IDLE, INIT, RUN and DONE.
REQ-012 IDLE with startIn=1 shall latch all configuration inputs, then:
- go to INIT if the configuration is legal;
- otherwise pulse errOut for one cycle and stay in IDLE.
REQ-013 A configuration is illegal if any dimension is 0, strideIn is 0, filtRowsIn > dataRowsIn, or filtColsIn > dataColsIn.
REQ-014 INIT shall last exactly one cycle and compute:
- outRows = (dataRows-filtRows)/stride+1;
- outCols = (dataCols-filtCols)/stride+1;
- beatsPerRow = ceil(filtCols/VECTOR_SIZE).
INIT then goes to RUN.
REQ-015 Iteration order, outermost to innermost: output row oy, output col ox, filter row fr, column chunk fc (stepping by VECTOR_SIZE); one beat per (oy,ox,fr,fc).
REQ-016 Lane i of each beat shall carry:
- dataAddr = dataBase + (oy*stride+fr)*dataCols + ox*stride + fc + i;
- filtAddr = filtBase + fr*filtCols + fc + i;
- laneValid[i] = (fc+i < filtCols).
REQ-017 Lanes whose laneValid bit is 0 shall drive address 0.
REQ-018 lastOut shall be 1 exactly on the beat with fr = filtRows-1 and fc + VECTOR_SIZE >= filtCols.
REQ-019 The first beat shall assert validOut on the second clkIn edge after the start-accepting edge.
REQ-020 A beat is accepted when validOut=1 and readyIn=1; with readyIn held high, the block shall issue one beat per cycle.
REQ-021 While validOut=1 and readyIn=0, all beat outputs shall hold stable.
REQ-022 Address arithmetic shall wrap modulo 2^ADDR_WIDTH; no overflow flag is produced.
REQ-023 After the final beat is accepted, the block shall enter DONE for one cycle, pulse doneOut, and return to IDLE.
REQ-024 startIn outside IDLE shall be ignored; input changes after latching shall not affect a run.
REQ-025 busyOut shall be 1 in INIT, RUN and DONE.

Reset
REQ-026 rstIn=0 at a clkIn edge, including mid-run, shall force IDLE and clear all counters.
REQ-027 Reset values: validOut, lastOut, busyOut, doneOut and errOut 0; laneValidOut 0; dataAddrOut and filtAddrOut 0.
REQ-028 A beat that is pending at reset shall be discarded and shall not reappear.

Structure
REQ-029 The state encoding, the lane-slice macro and the default widths shall live in the shared accelerator package cnn_accel_pkg.
REQ-030 The oy, ox, fr and fc loops shall each be an instance of the existing counter sub-module, chained by done/advance as in the base-counter scheme.
REQ-031 Row and column offsets shall be kept as running sums; no multipliers in the RUN datapath.

Verification
REQ-032 V=8; data 4x4; filt 3x3; stride 1; bases 0.
- Expect 12 beats.
- Beat 1: dataAddr 0,1,2; filtAddr 0,1,2; mask 0x07.
- Beat 3: dataAddr 8,9,10; filtAddr 6,7,8; lastOut=1.
- Beat 4: dataAddr 1,2,3.
REQ-033 V=8; data 1x10; filt 1x10; filtBase 100.
- Expect 2 beats.
- Beat 1: mask 0xFF; filtAddr 100..107.
- Beat 2: mask 0x03; filtAddr 108,109; lastOut=1; doneOut one cycle after acceptance.
REQ-034 Data 5x5; filt 3x3; stride 2.
- Expect 4 windows.
- The first beat of window (oy=1,ox=1) has dataAddr lane0 = 12.
REQ-035 Hold readyIn=0 for 3 cycles mid-run: outputs unchanged throughout; total beats still 12 for the REQ-032 setup.
REQ-036 startIn with filtRows=5, dataRows=4: errOut pulses once; busyOut stays 0; no validOut.
REQ-037 rstIn=0 for one cycle after beat 5 of REQ-032: all outputs 0 next cycle; a fresh start yields 12 beats from beat 1.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// Shared accelerator package.
// Holds the default widths, the address-generator FSM encoding and the
// lane-slice helper that locates lane i inside a packed multi-lane bus.
package cnn_accel_pkg;

  localparam int unsigned DEF_VECTOR_SIZE = 8;
  localparam int unsigned DEF_ADDR_WIDTH  = 12;
  localparam int unsigned DEF_DIM_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } win_state_e;

  // Lowest bit of lane 'lane' in a bus of 'width'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_counter.sv
// Loop counter used by the window address generator.
// Counts 0 .. limit-1 by one on each advance; 'done' is high while the count
// sits on its final value, so chained counters advance on (adv && done).
// Ports: clk, rst_n (synchronous, active-low), clr (restart at 0),
//        adv (step), limit (trip count), done (count is last value).
module conv_window_addr_gen_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   count_inc;

  // Next count and end-of-loop detection (extra bit avoids wrap at 2^WIDTH-1).
  always_comb begin
    count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    done      = (count_inc >= {1'b0, limit});
    if (clr) begin
      count_d = '0;
    end else if (adv) begin
      count_d = done ? '0 : count_inc[WIDTH-1:0];
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator.
// Walks every output position (oy, ox) of a strided 2-D convolution and, for
// each filter row and VECTOR_SIZE-wide column chunk, issues one beat holding
// per-lane data and filter element addresses plus a lane-valid mask.
// Ports: clkIn/rstIn (sync active-low); dims, stride and bases are latched
// on an accepted startIn; beats use validOut/readyIn; lastOut marks the final
// beat of a window; busyOut/doneOut/errOut report run status.
module conv_window_addr_gen
  import cnn_accel_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DIM_WIDTH   = DEF_DIM_WIDTH
) (
  input  logic                              clkIn,
  input  logic                              rstIn,
  input  logic [DIM_WIDTH-1:0]              dataRowsIn,
  input  logic [DIM_WIDTH-1:0]              dataColsIn,
  input  logic [DIM_WIDTH-1:0]              filtRowsIn,
  input  logic [DIM_WIDTH-1:0]              filtColsIn,
  input  logic [DIM_WIDTH-1:0]              strideIn,
  input  logic [ADDR_WIDTH-1:0]             dataBaseIn,
  input  logic [ADDR_WIDTH-1:0]             filtBaseIn,
  input  logic                              startIn,
  input  logic                              readyIn,
  output logic [VECTOR_SIZE*ADDR_WIDTH-1:0] dataAddrOut,
  output logic [VECTOR_SIZE*ADDR_WIDTH-1:0] filtAddrOut,
  output logic [VECTOR_SIZE-1:0]            laneValidOut,
  output logic                              validOut,
  output logic                              lastOut,
  output logic                              busyOut,
  output logic                              doneOut,
  output logic                              errOut
);

  localparam int unsigned LOG2V = $clog2(VECTOR_SIZE);
  localparam int unsigned BUS_W = VECTOR_SIZE * ADDR_WIDTH;

  win_state_e state_q, state_d;

  logic [DIM_WIDTH-1:0]  data_rows_q, data_rows_d, data_cols_q, data_cols_d;
  logic [DIM_WIDTH-1:0]  filt_rows_q, filt_rows_d, filt_cols_q, filt_cols_d;
  logic [DIM_WIDTH-1:0]  stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] data_base_q, data_base_d, filt_base_q, filt_base_d;
  logic [DIM_WIDTH-1:0]  out_rows_q, out_rows_d, out_cols_q, out_cols_d, beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] row_step_q, row_step_d;
  // Running sums: oy*stride*dataCols, ox*stride, fr*dataCols, fr*filtCols, fc.
  logic [ADDR_WIDTH-1:0] oy_off_q, oy_off_d, ox_off_q, ox_off_d;
  logic [ADDR_WIDTH-1:0] fr_doff_q, fr_doff_d, fr_foff_q, fr_foff_d;
  logic [DIM_WIDTH-1:0]  fc_elem_q, fc_elem_d;
  logic                  issued_all_q, issued_all_d;
  logic                  valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [VECTOR_SIZE-1:0] lane_valid_q, lane_valid_d;
  logic [BUS_W-1:0]      data_addr_q, data_addr_d, filt_addr_q, filt_addr_d;

  logic                  cfg_illegal, load, accept, clr_cnt;
  logic                  fc_last, fr_last, ox_last, oy_last;
  logic                  adv_fr, adv_ox, adv_oy;
  logic [DIM_WIDTH-1:0]  diff_rows, diff_cols;
  logic [DIM_WIDTH:0]    beats_sum;
  logic [31:0]           lane_col;
  logic [VECTOR_SIZE-1:0] lane_en;
  logic [BUS_W-1:0]      lane_data, lane_filt;

  assign cfg_illegal = (dataRowsIn == '0) || (dataColsIn == '0) || (filtRowsIn == '0) ||
                       (filtColsIn == '0) || (strideIn == '0) ||
                       (filtRowsIn > dataRowsIn) || (filtColsIn > dataColsIn);

  assign accept = valid_q && readyIn;
  assign adv_fr = load && fc_last;
  assign adv_ox = adv_fr && fr_last;
  assign adv_oy = adv_ox && ox_last;

  conv_window_addr_gen_counter #(.WIDTH(DIM_WIDTH)) u_fc_cnt (
    .clk(clkIn), .rst_n(rstIn), .clr(clr_cnt), .adv(load),   .limit(beats_q),     .done(fc_last)
  );
  conv_window_addr_gen_counter #(.WIDTH(DIM_WIDTH)) u_fr_cnt (
    .clk(clkIn), .rst_n(rstIn), .clr(clr_cnt), .adv(adv_fr), .limit(filt_rows_q), .done(fr_last)
  );
  conv_window_addr_gen_counter #(.WIDTH(DIM_WIDTH)) u_ox_cnt (
    .clk(clkIn), .rst_n(rstIn), .clr(clr_cnt), .adv(adv_ox), .limit(out_cols_q),  .done(ox_last)
  );
  conv_window_addr_gen_counter #(.WIDTH(DIM_WIDTH)) u_oy_cnt (
    .clk(clkIn), .rst_n(rstIn), .clr(clr_cnt), .adv(adv_oy), .limit(out_rows_q),  .done(oy_last)
  );

  // Per-lane addresses for the beat the counters currently point at.
  always_comb begin
    lane_col  = '0;
    lane_en   = '0;
    lane_data = '0;
    lane_filt = '0;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      lane_col   = 32'(fc_elem_q) + i;
      lane_en[i] = (lane_col < 32'(filt_cols_q));
      if (lane_en[i]) begin
        lane_data[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] =
          data_base_q + oy_off_q + fr_doff_q + ox_off_q + ADDR_WIDTH'(lane_col);
        lane_filt[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] =
          filt_base_q + fr_foff_q + ADDR_WIDTH'(lane_col);
      end else begin
        lane_data[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = '0;
        lane_filt[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = '0;
      end
    end
  end

  // Window-size arithmetic evaluated once, in INIT, from the latched config.
  always_comb begin
    diff_rows = data_rows_q - filt_rows_q;
    diff_cols = data_cols_q - filt_cols_q;
    beats_sum = {1'b0, filt_cols_q} + (DIM_WIDTH + 1)'(VECTOR_SIZE - 1);
  end

  // FSM next state, loop bookkeeping and next beat outputs.
  always_comb begin
    state_d      = state_q;
    data_rows_d  = data_rows_q;
    data_cols_d  = data_cols_q;
    filt_rows_d  = filt_rows_q;
    filt_cols_d  = filt_cols_q;
    stride_d     = stride_q;
    data_base_d  = data_base_q;
    filt_base_d  = filt_base_q;
    out_rows_d   = out_rows_q;
    out_cols_d   = out_cols_q;
    beats_d      = beats_q;
    row_step_d   = row_step_q;
    oy_off_d     = oy_off_q;
    ox_off_d     = ox_off_q;
    fr_doff_d    = fr_doff_q;
    fr_foff_d    = fr_foff_q;
    fc_elem_d    = fc_elem_q;
    issued_all_d = issued_all_q;
    valid_d      = valid_q;
    last_d       = last_q;
    lane_valid_d = lane_valid_q;
    data_addr_d  = data_addr_q;
    filt_addr_d  = filt_addr_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;
    clr_cnt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          data_rows_d = dataRowsIn;
          data_cols_d = dataColsIn;
          filt_rows_d = filtRowsIn;
          filt_cols_d = filtColsIn;
          stride_d    = strideIn;
          data_base_d = dataBaseIn;
          filt_base_d = filtBaseIn;
          if (cfg_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        out_rows_d   = diff_rows / stride_q + DIM_WIDTH'(1);
        out_cols_d   = diff_cols / stride_q + DIM_WIDTH'(1);
        beats_d      = DIM_WIDTH'(beats_sum >> LOG2V);
        // Only multiply in the block: one-off row step used by the oy running sum.
        row_step_d   = ADDR_WIDTH'(stride_q) * ADDR_WIDTH'(data_cols_q);
        oy_off_d     = '0;
        ox_off_d     = '0;
        fr_doff_d    = '0;
        fr_foff_d    = '0;
        fc_elem_d    = '0;
        issued_all_d = 1'b0;
        valid_d      = 1'b0;
        clr_cnt      = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        // Refill the output register when empty or when its beat is taken.
        load = !issued_all_q && (!valid_q || readyIn);
        if (load) begin
          valid_d      = 1'b1;
          lane_valid_d = lane_en;
          data_addr_d  = lane_data;
          filt_addr_d  = lane_filt;
          last_d       = fc_last && fr_last;
          issued_all_d = fc_last && fr_last && ox_last && oy_last;
          fc_elem_d    = fc_last ? '0 : fc_elem_q + DIM_WIDTH'(VECTOR_SIZE);
          fr_doff_d    = !adv_fr ? fr_doff_q : (fr_last ? '0 : fr_doff_q + ADDR_WIDTH'(data_cols_q));
          fr_foff_d    = !adv_fr ? fr_foff_q : (fr_last ? '0 : fr_foff_q + ADDR_WIDTH'(filt_cols_q));
          ox_off_d     = !adv_ox ? ox_off_q  : (ox_last ? '0 : ox_off_q + ADDR_WIDTH'(stride_q));
          oy_off_d     = !adv_oy ? oy_off_q  : (oy_last ? '0 : oy_off_q + row_step_q);
        end else if (accept) begin
          valid_d      = 1'b0;
          last_d       = 1'b0;
          lane_valid_d = '0;
          data_addr_d  = '0;
          filt_addr_d  = '0;
        end else begin
          valid_d = valid_q;
        end
        if (accept && issued_all_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration, running sums and registered outputs.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q      <= ST_IDLE;
      data_rows_q  <= '0;
      data_cols_q  <= '0;
      filt_rows_q  <= '0;
      filt_cols_q  <= '0;
      stride_q     <= '0;
      data_base_q  <= '0;
      filt_base_q  <= '0;
      out_rows_q   <= '0;
      out_cols_q   <= '0;
      beats_q      <= '0;
      row_step_q   <= '0;
      oy_off_q     <= '0;
      ox_off_q     <= '0;
      fr_doff_q    <= '0;
      fr_foff_q    <= '0;
      fc_elem_q    <= '0;
      issued_all_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lane_valid_q <= '0;
      data_addr_q  <= '0;
      filt_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_rows_q  <= data_rows_d;
      data_cols_q  <= data_cols_d;
      filt_rows_q  <= filt_rows_d;
      filt_cols_q  <= filt_cols_d;
      stride_q     <= stride_d;
      data_base_q  <= data_base_d;
      filt_base_q  <= filt_base_d;
      out_rows_q   <= out_rows_d;
      out_cols_q   <= out_cols_d;
      beats_q      <= beats_d;
      row_step_q   <= row_step_d;
      oy_off_q     <= oy_off_d;
      ox_off_q     <= ox_off_d;
      fr_doff_q    <= fr_doff_d;
      fr_foff_q    <= fr_foff_d;
      fc_elem_q    <= fc_elem_d;
      issued_all_q <= issued_all_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lane_valid_q <= lane_valid_d;
      data_addr_q  <= data_addr_d;
      filt_addr_q  <= filt_addr_d;
    end
  end

  assign dataAddrOut  = data_addr_q;
  assign filtAddrOut  = filt_addr_q;
  assign laneValidOut = lane_valid_q;
  assign validOut     = valid_q;
  assign lastOut      = last_q;
  assign busyOut      = busy_q;
  assign doneOut      = done_q;
  assign errOut       = err_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen: a table of configurations is
// applied in a loop; an independent multiply-based model pushes expected
// beats to a queue at start time and they are popped as beats are accepted.
module tb_conv_window_addr_gen;

  localparam int V  = 8;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstIn, startIn, readyIn;
  logic [DW-1:0] dataRowsIn, dataColsIn, filtRowsIn, filtColsIn, strideIn;
  logic [AW-1:0] dataBaseIn, filtBaseIn;
  logic [V*AW-1:0] dataAddrOut, filtAddrOut;
  logic [V-1:0] laneValidOut;
  logic validOut, lastOut, busyOut, doneOut, errOut;

  conv_window_addr_gen #(.VECTOR_SIZE(V), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clkIn(clk), .rstIn(rstIn),
    .dataRowsIn(dataRowsIn), .dataColsIn(dataColsIn), .filtRowsIn(filtRowsIn),
    .filtColsIn(filtColsIn), .strideIn(strideIn),
    .dataBaseIn(dataBaseIn), .filtBaseIn(filtBaseIn),
    .startIn(startIn), .readyIn(readyIn),
    .dataAddrOut(dataAddrOut), .filtAddrOut(filtAddrOut), .laneValidOut(laneValidOut),
    .validOut(validOut), .lastOut(lastOut), .busyOut(busyOut), .doneOut(doneOut), .errOut(errOut)
  );

  typedef struct {
    logic [V*AW-1:0] d;
    logic [V*AW-1:0] f;
    logic [V-1:0]    m;
    logic            l;
  } beat_t;

  typedef struct {
    int dr; int dc; int fr; int fc; int st; int db; int fb;
    int beats; bit err; int mode;  // mode: 0 ready high, 1 random ready + stray start, 2 3-cycle stall
  } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  vecs[8];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [V*AW-1:0] pack_seq(input int start, input int n);
    logic [V*AW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*AW +: AW] = AW'(start + i);
    return v;
  endfunction

  // Reference model: direct multiply form of the address equations.
  function automatic void model(input vec_t c);
    int orows, ocols;
    beat_t b;
    orows = (c.dr - c.fr) / c.st + 1;
    ocols = (c.dc - c.fc) / c.st + 1;
    for (int oy = 0; oy < orows; oy++)
      for (int ox = 0; ox < ocols; ox++)
        for (int r = 0; r < c.fr; r++)
          for (int k = 0; k < c.fc; k += V) begin
            b.d = '0; b.f = '0; b.m = '0;
            for (int i = 0; i < V; i++) begin
              if (k + i < c.fc) begin
                b.m[i] = 1'b1;
                b.d[i*AW +: AW] = AW'(c.db + (oy*c.st + r)*c.dc + ox*c.st + k + i);
                b.f[i*AW +: AW] = AW'(c.fb + r*c.fc + k + i);
              end
            end
            b.l = (r == c.fr - 1) && (k + V >= c.fc);
            exp_q.push_back(b);
          end
  endfunction

  task automatic scramble();
    dataRowsIn = DW'($urandom); dataColsIn = DW'($urandom); filtRowsIn = DW'($urandom);
    filtColsIn = DW'($urandom); strideIn = DW'($urandom);
    dataBaseIn = AW'($urandom); filtBaseIn = AW'($urandom);
  endtask

  task automatic run_vec(input vec_t c, input string tag, input int abort_after);
    int beats, cyc, last_acc, stall_cnt;
    bit done_seen, prev_stall;
    beat_t prev, e;
    beats = 0; cyc = 0; last_acc = -10; stall_cnt = 0; done_seen = 1'b0; prev_stall = 1'b0;
    prev.d = '0; prev.f = '0; prev.m = '0; prev.l = 1'b0;
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    dataRowsIn = DW'(c.dr); dataColsIn = DW'(c.dc); filtRowsIn = DW'(c.fr);
    filtColsIn = DW'(c.fc); strideIn = DW'(c.st);
    dataBaseIn = AW'(c.db); filtBaseIn = AW'(c.fb);
    startIn = 1'b1; readyIn = 1'b1;
    if (!c.err) model(c);
    @(negedge clk);
    startIn = 1'b0;
    scramble();
    if (c.err) begin
      check({tag, " err pulse"}, 128'({errOut, busyOut, validOut}), 128'(3'b100));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("%s quiet%0d", tag, k), 128'({errOut, busyOut, validOut}), 128'(3'b000));
      end
      return;
    end
    check({tag, " init busy"}, 128'({busyOut, validOut}), 128'(2'b10));
    @(negedge clk);
    check({tag, " pre-valid"}, 128'(validOut), 128'(1'b0));
    @(negedge clk);
    check({tag, " latency"}, 128'(validOut), 128'(1'b1));
    while (!done_seen && cyc < 400) begin
      if (prev_stall) begin
        check($sformatf("%s hold data c%0d", tag, cyc), 128'(dataAddrOut), 128'(prev.d));
        check($sformatf("%s hold filt c%0d", tag, cyc), 128'(filtAddrOut), 128'(prev.f));
        check($sformatf("%s hold ctl c%0d", tag, cyc), 128'({validOut, lastOut, laneValidOut}),
              128'({1'b1, prev.l, prev.m}));
      end
      case (c.mode)
        1: readyIn = 1'($urandom_range(0, 1));
        2: begin
          readyIn = !(beats >= 4 && stall_cnt < 3);
          if (!readyIn) stall_cnt++;
        end
        default: readyIn = 1'b1;
      endcase
      startIn = (c.mode == 1) && !doneOut && 1'($urandom_range(0, 1));
      if (c.mode == 1) scramble();
      if (doneOut) begin
        done_seen = 1'b1;
        startIn = 1'b0;
        check({tag, " done timing"}, 128'(cyc), 128'(last_acc + 1));
      end
      if (validOut && readyIn) begin
        e.d = dataAddrOut; e.f = filtAddrOut; e.m = laneValidOut; e.l = lastOut;
        got_q.push_back(e);
        if (exp_q.size() == 0) begin
          check($sformatf("%s extra beat%0d", tag, beats), 128'(1), 128'(0));
        end else begin
          prev = exp_q.pop_front();
          check($sformatf("%s b%0d data", tag, beats), 128'(e.d), 128'(prev.d));
          check($sformatf("%s b%0d filt", tag, beats), 128'(e.f), 128'(prev.f));
          check($sformatf("%s b%0d mask", tag, beats), 128'(e.m), 128'(prev.m));
          check($sformatf("%s b%0d last", tag, beats), 128'(e.l), 128'(prev.l));
        end
        beats++;
        last_acc = cyc;
        if (abort_after > 0 && beats == abort_after) return;
      end
      prev_stall = validOut && !readyIn;
      prev.d = dataAddrOut; prev.f = filtAddrOut; prev.m = laneValidOut; prev.l = lastOut;
      if (!done_seen) begin
        cyc++;
        @(negedge clk);
      end
    end
    check({tag, " done seen"}, 128'(done_seen), 128'(1'b1));
    check({tag, " beat count"}, 128'(beats), 128'(c.beats));
    check({tag, " queue empty"}, 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    check({tag, " back idle"}, 128'({busyOut, doneOut, validOut}), 128'(3'b000));
  endtask

  initial begin
    vecs[0] = '{4, 4, 3, 3, 1, 0, 0, 12, 1'b0, 0};
    vecs[1] = '{1, 10, 1, 10, 1, 0, 100, 2, 1'b0, 0};
    vecs[2] = '{5, 5, 3, 3, 2, 0, 0, 12, 1'b0, 1};
    vecs[3] = '{4, 4, 5, 3, 1, 0, 0, 0, 1'b1, 0};
    vecs[4] = '{4, 4, 3, 3, 0, 0, 0, 0, 1'b1, 0};
    vecs[5] = '{3, 20, 2, 17, 3, 4090, 4000, 12, 1'b0, 1};
    vecs[6] = '{1, 1, 1, 1, 1, 7, 9, 1, 1'b0, 0};
    vecs[7] = '{4, 4, 3, 0, 1, 0, 0, 0, 1'b1, 0};

    rstIn = 1'b0; startIn = 1'b0; readyIn = 1'b1;
    scramble();
    repeat (3) @(negedge clk);
    check("reset ctl", 128'({validOut, lastOut, busyOut, doneOut, errOut, laneValidOut}), 128'(0));
    check("reset data", 128'(dataAddrOut), 128'(0));
    check("reset filt", 128'(filtAddrOut), 128'(0));
    rstIn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0);
      if (i == 0 && got_q.size() >= 4) begin
        check("v0 beat1 data", 128'(got_q[0].d), 128'(pack_seq(0, 3)));
        check("v0 beat1 filt", 128'(got_q[0].f), 128'(pack_seq(0, 3)));
        check("v0 beat1 mask", 128'(got_q[0].m), 128'(8'h07));
        check("v0 beat3 data", 128'(got_q[2].d), 128'(pack_seq(8, 3)));
        check("v0 beat3 filt", 128'(got_q[2].f), 128'(pack_seq(6, 3)));
        check("v0 beat3 last", 128'(got_q[2].l), 128'(1'b1));
        check("v0 beat4 data", 128'(got_q[3].d), 128'(pack_seq(1, 3)));
      end else if (i == 1 && got_q.size() >= 2) begin
        check("v1 beat1 mask", 128'(got_q[0].m), 128'(8'hFF));
        check("v1 beat1 filt", 128'(got_q[0].f), 128'(pack_seq(100, 8)));
        check("v1 beat2 mask", 128'(got_q[1].m), 128'(8'h03));
        check("v1 beat2 filt", 128'(got_q[1].f), 128'(pack_seq(108, 2)));
        check("v1 beat2 last", 128'(got_q[1].l), 128'(1'b1));
      end else if (i == 2 && got_q.size() >= 10) begin
        check("v2 win11 lane0", 128'(got_q[9].d[AW-1:0]), 128'(12));
      end
    end

    // Back-pressure: three stalled cycles mid-run.
    begin
      vec_t s;
      s = vecs[0];
      s.mode = 2;
      run_vec(s, "stall", 0);
    end

    // Reset after the fifth beat, then a clean rerun.
    run_vec(vecs[0], "abort", 5);
    @(negedge clk);
    rstIn = 1'b0;
    @(negedge clk);
    check("midrst ctl", 128'({validOut, lastOut, busyOut, doneOut, errOut, laneValidOut}), 128'(0));
    check("midrst data", 128'(dataAddrOut), 128'(0));
    check("midrst filt", 128'(filtAddrOut), 128'(0));
    rstIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst quiet%0d", k), 128'({validOut, busyOut}), 128'(2'b00));
    end
    run_vec(vecs[0], "rerun", 0);
    if (got_q.size() >= 1) begin
      check("rerun beat1 data", 128'(got_q[0].d), 128'(pack_seq(0, 3)));
    end else begin
      check("rerun beat1 present", 128'(got_q.size()), 128'(12));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
